fifo_circ_param: RTL and testbench
==================================

Name: fifo_circ_param

Overview:
- Parametrised circular FIFO; successor to the fixed 8-entry, 512-bit operand FIFO used ahead of the ECC multipliers.
- Generalised in data width and depth.
- Adds:
  - correct simultaneous read/write at the full boundary
  - occupancy level output
  - almost-full/almost-empty thresholds
  - registered read-valid
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits between the sequential state machine and the multiplier datapaths as an operand/result buffer.

Parameters:
- DATA_W, 512, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two, ≥2.
- AF_THRESH, DEPTH-2, almost_full asserts when level ≥ AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when level ≤ AE_THRESH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO contents and error flags.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- Data_in  in  DATA_W  write data.
- Data_out  out  DATA_W  registered read data.
- rd_valid  out  1  Data_out updated this cycle with a popped word.
- In_Busy  out  1  full (level == DEPTH).
- Out_Busy  out  1  empty (level == 0).
- almost_full  out  1  level ≥ AF_THRESH.
- almost_empty  out  1  level ≤ AE_THRESH.
- level  out  AW+1  current occupancy, 0..DEPTH (AW = clog2(DEPTH)).
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was dropped.

Behaviour:
- State:
  - wr_ptr, rd_ptr: AW bits each; wrap naturally modulo DEPTH, no explicit modulo.
  - level: AW+1 bits.
  - Memory array: not reset.
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, level = 0; Data_out = 0; rd_valid, overflow, underflow = 0.
  - Status outputs follow from level = 0: In_Busy = 0, Out_Busy = 1, almost_empty = 1.
- Flags:
  - In_Busy, Out_Busy, almost_full, almost_empty are combinational from the level register.
  - They change the cycle after the causing edge.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = rd_en && level != 0.
  - wr_acc = wr_en && (level != DEPTH || rd_acc).
  - Write while full is accepted only when paired with an accepted read.
  - Read while empty is never accepted; there is no write-through bypass.
- On wr_acc: mem[wr_ptr] <= Data_in; wr_ptr increments.
- On rd_acc:
  - Data_out <= mem[rd_ptr]; read-before-write when wr_ptr == rd_ptr in the same cycle.
  - rd_ptr increments; rd_valid <= 1.
  - Otherwise rd_valid <= 0 and Data_out holds.
- Read latency: 1 cycle from the accepting edge.
- level update:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged when both or neither.
- Errors (sticky until flush or reset):
  - overflow <= 1 on wr_en && !wr_acc.
  - underflow <= 1 on rd_en && !rd_acc.
- flush has priority over wr_en/rd_en in the same cycle:
  - Pointers, level, overflow, underflow → 0; rd_valid → 0.
  - Data_out holds; memory untouched.
- Reset mid-operation: all state returns to reset values immediately; in-flight requests are lost.

Decomposition:
- Shared package/header fifo_pkg:
  - clog2 constant function.
  - Default DATA_W (512) and DEPTH (8) constants shared with multiplier wrappers.
- One sub-module: fifo_dpram.
  - Simple dual-port RAM, DATA_W × DEPTH.
  - One synchronous write port.
  - One registered read port with read-enable, read-before-write semantics.
- Top-level holds pointers, level, flags and errors.

Test Plan:
- Reset then fill: 8 writes of 0x1..0x8, no reads → level 8, In_Busy = 1, almost_full from level 6; 9th write → overflow = 1, level stays 8.
- Drain: 8 reads after fill → Data_out 0x1..0x8 in order, each with rd_valid one cycle after rd_en; Out_Busy = 1 after the last; extra read → underflow = 1, rd_valid = 0.
- Full + simultaneous rd/wr: at level 8, wr_en = rd_en = 1 with Data_in = 0xA5 → Data_out = oldest word, level stays 8, no overflow; 0xA5 emerges after 7 more reads.
- Empty + simultaneous rd/wr: level 0, both asserted with 0x33 → write accepted, read rejected, underflow = 1, level 1; next read returns 0x33.
- Wrap-around: 20 interleaved push/pop cycles at level 3 with an incrementing pattern → output sequence strictly increments; pointers wrap with no loss.
- Flush/reset: level 5 plus overflow set, flush with wr_en = 1 → level 0, overflow = 0, write discarded; rst_n low mid-burst → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the operand/result FIFO and its users.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 512;
  localparam int unsigned FIFO_DEPTH  = 8;

  // Ceiling log2, used to size pointers from a depth parameter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port with read enable. A same-address read and write in one cycle returns
// the old contents.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned AW     = clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_circ_param.sv
// Parametrised circular FIFO buffering operands/results between the
// sequencer and the multiplier datapaths. Tracks occupancy, threshold
// flags and sticky overflow/underflow errors; read data is registered.
module fifo_circ_param
  import fifo_pkg::*;
#(
  parameter  int unsigned DATA_W    = FIFO_DATA_W,
  parameter  int unsigned DEPTH     = FIFO_DEPTH,
  parameter  int unsigned AF_THRESH = DEPTH - 2,
  parameter  int unsigned AE_THRESH = 1,
  localparam int unsigned AW        = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              rd_valid,
  output logic              In_Busy,
  output logic              Out_Busy,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              underflow
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  // Accept decisions on pre-edge state, then next-state for all registers.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // A write to a full FIFO is only taken when a read frees a slot.
    rd_acc = !flush && rd_en && (level_q != '0);
    wr_acc = !flush && wr_en && ((level_q != (AW+1)'(DEPTH)) || rd_acc);

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_valid_d = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
      if (wr_en && !wr_acc) begin
        overflow_d = 1'b1;
      end
      if (rd_en && !rd_acc) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Pointer, occupancy and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (Data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (Data_out)
  );

  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign level        = level_q;
  assign In_Busy      = (level_q == (AW+1)'(DEPTH));
  assign Out_Busy     = (level_q == '0);
  assign almost_full  = (32'(level_q) >= AF_THRESH);
  assign almost_empty = (32'(level_q) <= AE_THRESH);

endmodule

// File: tb/tb_fifo_circ_param.sv
// Randomised scoreboard bench for fifo_circ_param against a queue model.
module tb_fifo_circ_param;
  import fifo_pkg::*;

  localparam int unsigned DW    = FIFO_DATA_W;
  localparam int unsigned DEP   = FIFO_DEPTH;
  localparam int unsigned AFT   = DEP - 2;
  localparam int unsigned AET   = 1;
  localparam int unsigned LW    = clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, wr_en, rd_en;
  logic [DW-1:0] Data_in, Data_out;
  logic          rd_valid, In_Busy, Out_Busy, almost_full, almost_empty;
  logic [LW-1:0] level;
  logic          overflow, underflow;

  fifo_circ_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .Data_in      (Data_in),
    .Data_out     (Data_out),
    .rd_valid     (rd_valid),
    .In_Busy      (In_Busy),
    .Out_Busy     (Out_Busy),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   lvl;
    logic          rv;
    logic          ovf;
    logic          unf;
    logic [DW-1:0] dout;
  } exp_t;

  // Reference model state
  logic [DW-1:0] model_q[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_dout;

  exp_t          stq[$];
  logic [DW-1:0] dq[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk_status(input string tag, input exp_t e);
    chk({tag, ".level"},        DW'(level),        DW'(e.lvl));
    chk({tag, ".In_Busy"},      DW'(In_Busy),      DW'(e.lvl == DEP));
    chk({tag, ".Out_Busy"},     DW'(Out_Busy),     DW'(e.lvl == 0));
    chk({tag, ".almost_full"},  DW'(almost_full),  DW'(e.lvl >= AFT));
    chk({tag, ".almost_empty"}, DW'(almost_empty), DW'(e.lvl <= AET));
    chk({tag, ".rd_valid"},     DW'(rd_valid),     DW'(e.rv));
    chk({tag, ".overflow"},     DW'(overflow),     DW'(e.ovf));
    chk({tag, ".underflow"},    DW'(underflow),    DW'(e.unf));
    chk({tag, ".Data_out"},     Data_out,          e.dout);
  endtask

  // One clock of stimulus; the model decides what the FIFO should accept.
  task automatic step(input logic wr, input logic rd, input logic fl, input logic [DW-1:0] din);
    exp_t e;
    logic racc, wacc;
    @(negedge clk);
    wr_en = wr; rd_en = rd; flush = fl; Data_in = din;
    e.rv = 1'b0;
    if (fl) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      racc = rd && (model_q.size() > 0);
      wacc = wr && ((model_q.size() < DEP) || racc);
      if (racc) begin
        m_dout = model_q.pop_front();
        dq.push_back(m_dout);
        e.rv = 1'b1;
      end
      if (wacc) model_q.push_back(din);
      if (wr && !wacc) m_ovf = 1'b1;
      if (rd && !racc) m_unf = 1'b1;
    end
    e.lvl  = model_q.size();
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    e.dout = m_dout;
    stq.push_back(e);
    @(posedge clk);
    #3;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  // Monitor: compare status every stepped cycle, pop read data on rd_valid.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst_n && stq.size() > 0) begin
      e = stq.pop_front();
      chk_status("cyc", e);
      if (rd_valid) begin
        if (dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_data: got rd_valid with %0h, expected no read", Data_out);
        end else begin
          chk("rd_data", Data_out, dq.pop_front());
        end
      end
    end
  end

  task automatic reset_check(input string tag);
    exp_t e;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    stq.delete();
    dq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    e.lvl = 0; e.rv = 1'b0; e.ovf = 1'b0; e.unf = 1'b0; e.dout = '0;
    chk_status(tag, e);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; Data_in = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    repeat (2) @(posedge clk);
    #3;
    reset_check("reset");

    // Fill with 1..8, then one write too many
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
    // Drain all eight, then one read too many
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Full plus simultaneous read/write
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, DW'(i + 16));
    step(1'b1, 1'b1, 1'b0, DW'(32'hA5));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Empty plus simultaneous read/write
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b0, DW'(32'h33));
    step(1'b0, 1'b1, 1'b0, '0);

    // Wrap-around at level 3 with incrementing data
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, DW'(100 + i));
    for (int i = 3; i < 23; i++) step(1'b1, 1'b1, 1'b0, DW'(100 + i));

    // Level 5 with overflow set, then flush alongside a write
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, rand_word());
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, rand_word());
    step(1'b0, 1'b1, 1'b0, '0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 2), rand_word());
    end

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, rand_word());
    wr_en = 1'b1; rd_en = 1'b1;
    reset_check("midreset");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, rand_word());
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0);

    repeat (2) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
